// File: rtl/fpu_issue_queue.sv
// FPU issue queue: a DEPTH-entry FIFO of {op, rmode, opa, opb} in front of the FPU datapath.
// Each operand is classified as nan/inf/denorm/zero when it is pushed, and a special-case
// flag is computed for the downstream fast path. Illegal opcodes are consumed, dropped and counted.
module fpu_issue_queue #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int DEPTH = 4,
    parameter int ERR_W = 8,
    localparam int FW   = 1 + EXP_W + MAN_W,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [1:0]       in_rmode,
    input  logic [FW-1:0]    in_opa,
    input  logic [FW-1:0]    in_opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_op,
    output logic [1:0]       out_rmode,
    output logic [FW-1:0]    out_opa,
    output logic [FW-1:0]    out_opb,
    output logic [3:0]       out_cls_a,
    output logic [3:0]       out_cls_b,
    output logic             out_special,
    output logic [CW-1:0]    count,
    output logic             illegal_op,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [2:0]       OP_MULT  = 3'd2;
    localparam logic [2:0]       OP_DIV   = 3'd3;

    // Class encoding {nan, inf, denorm, zero}; all zero means a normal number.
    localparam logic [3:0] CLS_NAN    = 4'b1000;
    localparam logic [3:0] CLS_INF    = 4'b0100;
    localparam logic [3:0] CLS_DENORM = 4'b0010;
    localparam logic [3:0] CLS_ZERO   = 4'b0001;

    logic [2:0]    op_mem      [DEPTH];
    logic [1:0]    rmode_mem   [DEPTH];
    logic [FW-1:0] opa_mem     [DEPTH];
    logic [FW-1:0] opb_mem     [DEPTH];
    logic [3:0]    cls_a_mem   [DEPTH];
    logic [3:0]    cls_b_mem   [DEPTH];
    logic          special_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic [3:0]    cls_a;
    logic [3:0]    cls_b;
    logic          special;

    function automatic logic [3:0] classify(input logic [FW-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = x[FW-2 -: EXP_W];
        m = x[MAN_W-1:0];
        classify = 4'b0000;
        if (&e) begin
            classify = (|m) ? CLS_NAN : CLS_INF;
        end else if (e == '0) begin
            classify = (|m) ? CLS_DENORM : CLS_ZERO;
        end
    endfunction

    // Illegal opcodes (bit 2 set) are accepted on the handshake but never stored;
    // a full queue refuses everything, so nothing is consumed then.
    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready && !in_op[2];
    assign drop     = in_valid && in_ready && in_op[2];
    assign pop      = !empty && out_ready;

    // A zero operand only fixes the result for MULT and DIV; denormals never do.
    assign cls_a   = classify(in_opa);
    assign cls_b   = classify(in_opb);
    assign special = cls_a[3] | cls_b[3] | cls_a[2] | cls_b[2]
                   | (((in_op == OP_MULT) || (in_op == OP_DIV)) && (cls_a[0] | cls_b[0]));

    // Storage write on an accepted push; contents need no reset because pointers gate them.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            op_mem[wr_ptr]      <= in_op;
            rmode_mem[wr_ptr]   <= in_rmode;
            opa_mem[wr_ptr]     <= in_opa;
            opb_mem[wr_ptr]     <= in_opb;
            cls_a_mem[wr_ptr]   <= cls_a;
            cls_b_mem[wr_ptr]   <= cls_b;
            special_mem[wr_ptr] <= special;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Dropped-instruction pulse and saturating counter; flush does not hide or clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_op <= 1'b0;
            err_cnt    <= '0;
        end else begin
            illegal_op <= drop;
            if (drop && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    // Head entry presented straight from storage, forced to zero while the queue is empty.
    always_comb begin
        out_op      = '0;
        out_rmode   = '0;
        out_opa     = '0;
        out_opb     = '0;
        out_cls_a   = '0;
        out_cls_b   = '0;
        out_special = 1'b0;
        if (!empty) begin
            out_op      = op_mem[rd_ptr];
            out_rmode   = rmode_mem[rd_ptr];
            out_opa     = opa_mem[rd_ptr];
            out_opb     = opb_mem[rd_ptr];
            out_cls_a   = cls_a_mem[rd_ptr];
            out_cls_b   = cls_b_mem[rd_ptr];
            out_special = special_mem[rd_ptr];
        end
    end

    assign out_valid = !empty;
    assign count     = cnt;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Testbench for fpu_issue_queue: a stimulus process updates a queue-based reference model,
// and a separate monitor compares the DUT against it every cycle. A second, binary16
// instance with a 2-bit error counter covers saturation and narrow-format classification.
module tb_fpu_issue_queue;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int DEPTH = 4;
    localparam int ERR_W = 8;
    localparam int FW    = 1 + EXP_W + MAN_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int ERR_SAT = (1 << ERR_W) - 1;

    typedef struct {
        logic [2:0]    op;
        logic [1:0]    rmode;
        logic [FW-1:0] opa;
        logic [FW-1:0] opb;
        logic [3:0]    ca;
        logic [3:0]    cb;
        logic          sp;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [2:0]       in_op = '0;
    logic [1:0]       in_rmode = '0;
    logic [FW-1:0]    in_opa = '0;
    logic [FW-1:0]    in_opb = '0;
    logic             in_ready;
    logic             out_valid;
    logic [2:0]       out_op;
    logic [1:0]       out_rmode;
    logic [FW-1:0]    out_opa;
    logic [FW-1:0]    out_opb;
    logic [3:0]       out_cls_a;
    logic [3:0]       out_cls_b;
    logic             out_special;
    logic [CW-1:0]    count;
    logic             illegal_op;
    logic [ERR_W-1:0] err_cnt;

    logic        h_flush = 1'b0;
    logic        h_in_valid = 1'b0;
    logic        h_out_ready = 1'b0;
    logic [2:0]  h_in_op = '0;
    logic [1:0]  h_in_rmode = '0;
    logic [15:0] h_in_opa = '0;
    logic [15:0] h_in_opb = '0;
    logic        h_in_ready;
    logic        h_out_valid;
    logic [2:0]  h_out_op;
    logic [1:0]  h_out_rmode;
    logic [15:0] h_out_opa;
    logic [15:0] h_out_opb;
    logic [3:0]  h_out_cls_a;
    logic [3:0]  h_out_cls_b;
    logic        h_out_special;
    logic [2:0]  h_count;
    logic        h_illegal_op;
    logic [1:0]  h_err_cnt;

    entry_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     ill_next = 1'b0;
    int     err_model = 0;
    bit     mon_en = 1'b0;

    fpu_issue_queue #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rmode(in_rmode), .in_opa(in_opa), .in_opb(in_opb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rmode(out_rmode), .out_opa(out_opa), .out_opb(out_opb),
        .out_cls_a(out_cls_a), .out_cls_b(out_cls_b), .out_special(out_special),
        .count(count), .illegal_op(illegal_op), .err_cnt(err_cnt)
    );

    fpu_issue_queue #(.EXP_W(5), .MAN_W(10), .DEPTH(4), .ERR_W(2)) dut_h (
        .clk(clk), .rst(rst), .flush(h_flush),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_op(h_in_op), .in_rmode(h_in_rmode), .in_opa(h_in_opa), .in_opb(h_in_opb),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_op(h_out_op), .out_rmode(h_out_rmode), .out_opa(h_out_opa), .out_opb(h_out_opb),
        .out_cls_a(h_out_cls_a), .out_cls_b(h_out_cls_b), .out_special(h_out_special),
        .count(h_count), .illegal_op(h_illegal_op), .err_cnt(h_err_cnt)
    );

    always #5 clk = ~clk;

    // Reference classification straight from the field values of an IEEE-style number.
    function automatic logic [3:0] refClass(input longint unsigned x, input int ew, input int mw);
        longint unsigned e;
        longint unsigned m;
        longint unsigned emax;
        emax = (64'd1 << ew) - 64'd1;
        e    = (x >> mw) & emax;
        m    = x & ((64'd1 << mw) - 64'd1);
        if (e == emax) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 0)    return (m != 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    function automatic entry_t makeEntry(input logic [2:0] op, input logic [1:0] rm,
                                         input logic [FW-1:0] a, input logic [FW-1:0] b);
        entry_t t;
        bit any_nan;
        bit any_inf;
        bit any_zero;
        t.op    = op;
        t.rmode = rm;
        t.opa   = a;
        t.opb   = b;
        t.ca    = refClass(longint'(a), EXP_W, MAN_W);
        t.cb    = refClass(longint'(b), EXP_W, MAN_W);
        any_nan  = (t.ca == 4'b1000) || (t.cb == 4'b1000);
        any_inf  = (t.ca == 4'b0100) || (t.cb == 4'b0100);
        any_zero = (t.ca == 4'b0001) || (t.cb == 4'b0001);
        t.sp = any_nan || any_inf || (((op == 3'd2) || (op == 3'd3)) && any_zero);
        return t;
    endfunction

    function automatic logic [FW-1:0] pickOperand();
        logic [FW-1:0] r;
        r = FW'($urandom);
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'h7FC0_0001;
            4: return {r[31], 8'h00, r[22:0]};
            5: return {r[31], 8'hFF, r[22:0]};
            default: return r;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Drives one cycle of inputs just after the falling edge and records what the queue
    // should do with them at the coming rising edge.
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [1:0] rm,
                                 input logic [FW-1:0] a, input logic [FW-1:0] b,
                                 input logic ordy, input logic fl);
        bit accepted;
        @(negedge clk);
        #1;
        in_valid  = v;
        in_op     = op;
        in_rmode  = rm;
        in_opa    = a;
        in_opb    = b;
        out_ready = ordy;
        flush     = fl;
        #1;
        accepted = v && (exp_q.size() < DEPTH);
        ill_next = accepted && (op > 3'd3);
        if (ill_next && (err_model < ERR_SAT)) err_model++;
        if (fl) exp_q.delete();
        else if (accepted && (op <= 3'd3)) exp_q.push_back(makeEntry(op, rm, a, b));
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 3'd0, 2'd0, '0, '0, ordy, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        exp_q.delete();
        ill_next  = 1'b0;
        err_model = 0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_op", out_op, 0);
        checkOutput("rst_out_opa", out_opa, 0);
        checkOutput("rst_out_opb", out_opb, 0);
        checkOutput("rst_out_cls", {out_cls_a, out_cls_b}, 0);
        checkOutput("rst_out_special", out_special, 0);
        checkOutput("rst_illegal_op", illegal_op, 0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares the DUT against the model each cycle and retires the head entry
    // whenever the consumer takes it.
    initial begin
        bit nonempty;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                nonempty = (exp_q.size() > 0);
                checkOutput("count", count, exp_q.size());
                checkOutput("in_ready", in_ready, exp_q.size() < DEPTH);
                checkOutput("out_valid", out_valid, nonempty);
                checkOutput("illegal_op", illegal_op, ill_next);
                checkOutput("err_cnt", err_cnt, err_model);
                if (nonempty) begin
                    checkOutput("out_op", out_op, exp_q[0].op);
                    checkOutput("out_rmode", out_rmode, exp_q[0].rmode);
                    checkOutput("out_opa", out_opa, exp_q[0].opa);
                    checkOutput("out_opb", out_opb, exp_q[0].opb);
                    checkOutput("out_cls_a", out_cls_a, exp_q[0].ca);
                    checkOutput("out_cls_b", out_cls_b, exp_q[0].cb);
                    checkOutput("out_special", out_special, exp_q[0].sp);
                end
                #3;
                if (nonempty && out_ready && !flush && !rst) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [2:0] rop;
        int r;
        $display("[TB] start");
        doReset();
        mon_en = 1'b1;

        // Single ADD of 1.0 and 2.0 shows up one cycle later as a plain normal entry.
        applyStimulus(1'b1, 3'd0, 2'd0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("ex1_out_valid", out_valid, 1);
        checkOutput("ex1_cls", {out_cls_a, out_cls_b}, 0);
        checkOutput("ex1_special", out_special, 0);
        checkOutput("ex1_count", count, 1);
        idle(1'b1);
        idle(1'b0);

        // Fill to capacity, offer a fifth entry, then pop while full and push+pop at two.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 3'(i % 4), 2'(i % 4), 32'h4000_0000 + 32'(i), 32'h3F00_0000 + 32'(i), 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("full_count", count, 4);
        checkOutput("full_in_ready", in_ready, 0);
        applyStimulus(1'b1, 3'd0, 2'd1, 32'h4110_0000, 32'h4120_0000, 1'b1, 1'b0);
        idle(1'b0);
        checkOutput("full_pushpop_count", count, 3);
        idle(1'b1);
        applyStimulus(1'b1, 3'd2, 2'd1, 32'h4130_0000, 32'h4140_0000, 1'b1, 1'b0);
        idle(1'b0);
        checkOutput("two_pushpop_count", count, 2);
        repeat (3) idle(1'b1);
        idle(1'b0);

        // Illegal opcode: dropped, one pulse, counter at one.
        applyStimulus(1'b1, 3'd5, 2'd0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("ill_pulse", illegal_op, 1);
        checkOutput("ill_err_cnt", err_cnt, 1);
        checkOutput("ill_not_stored", count, 0);

        // MULT 0 x inf is special; DIV of a denormal by a normal is not.
        applyStimulus(1'b1, 3'd2, 2'd0, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("mult_cls_a", out_cls_a, 4'b0001);
        checkOutput("mult_cls_b", out_cls_b, 4'b0100);
        checkOutput("mult_special", out_special, 1);
        idle(1'b1);
        applyStimulus(1'b1, 3'd3, 2'd3, 32'h0000_0001, 32'h4000_0000, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("div_cls_a", out_cls_a, 4'b0010);
        checkOutput("div_special", out_special, 0);
        idle(1'b1);

        // Three queued, flush with a simultaneous push and an illegal op in flight.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 3'd1, 2'd2, 32'h4040_0000 + 32'(i), 32'hC040_0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd0, 2'd0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b1);
        idle(1'b0);
        checkOutput("flush_count", count, 0);
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_err_cnt", err_cnt, 1);
        applyStimulus(1'b1, 3'd6, 2'd0, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd7, 2'd0, '0, '0, 1'b0, 1'b1);
        idle(1'b0);
        checkOutput("flush_ill_err_cnt", err_cnt, 3);

        // Reset in the middle of traffic, then a push behaves as on an empty queue.
        applyStimulus(1'b1, 3'd0, 2'd0, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd1, 2'd0, 32'h4040_0000, 32'h4000_0000, 1'b0, 1'b0);
        doReset();
        applyStimulus(1'b1, 3'd2, 2'd1, 32'h7FC0_0000, 32'h4000_0000, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("post_rst_count", count, 1);
        checkOutput("post_rst_opa", out_opa, 32'h7FC0_0000);
        idle(1'b1);

        // Randomised traffic with backpressure, illegal ops and occasional flushes.
        for (int n = 0; n < 400; n++) begin
            r   = $urandom_range(0, 15);
            rop = (r < 12) ? 3'(r % 4) : 3'(4 + r % 4);
            applyStimulus(($urandom_range(0, 9) < 7), rop, 2'($urandom_range(0, 3)),
                          pickOperand(), pickOperand(), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 39) == 0));
        end
        repeat (6) idle(1'b1);
        idle(1'b0);

        // Binary16 instance with a 2-bit counter: saturation and narrow-format NaN.
        @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            h_in_valid = 1'b1;
            h_in_op    = 3'(4 + i % 4);
            @(negedge clk);
            #1;
            checkOutput("h_err_cnt", h_err_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        h_in_valid = 1'b1;
        h_in_op    = 3'd0;
        h_in_opa   = 16'h7C01;
        h_in_opb   = 16'h3C00;
        @(negedge clk);
        #1;
        h_in_valid = 1'b0;
        checkOutput("h_out_valid", h_out_valid, 1);
        checkOutput("h_cls_a", h_out_cls_a, 4'b1000);
        checkOutput("h_cls_a_model", h_out_cls_a, refClass(64'h7C01, 5, 10));
        checkOutput("h_cls_b", h_out_cls_b, 4'b0000);
        checkOutput("h_special", h_out_special, 1);
        checkOutput("h_count", h_count, 1);
        checkOutput("h_err_hold", h_err_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
